// File: rtl/x9_pkg.sv
// Shared types and default constants for the X9 instruction sequencer slice.
package x9_pkg;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED, ERROR
  } seq_state_t;

  localparam int         MCODEBITS_DEF   = 5;
  localparam logic [4:0] HALT_OP_DEF     = 5'b11111;
  localparam int         MEM_TIMEOUT_DEF = 15;
  localparam int         CNTW_DEF        = 16;
  // Wide enough for any MEM_TIMEOUT in 1..255.
  localparam int         TIMER_W         = 8;

endpackage

// File: rtl/x9_wait_timer.sv
// Clear/enable cycle counter with a terminal-count flag, used to bound data-memory waits.
module x9_wait_timer
  import x9_pkg::*;
#(
  parameter int W     = TIMER_W,
  parameter int LIMIT = MEM_TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count: this is the last waiting cycle that is still allowed.
  assign tc_o = (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/x9_inst_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the X9 datapath.
// Strobes are decoded combinationally from the current state and the control-decoder
// outputs (which only change on ir_load); done, error and inst_count are registered.
module x9_inst_sequencer
  import x9_pkg::*;
#(
  parameter int                   MCODEBITS   = MCODEBITS_DEF,
  parameter logic [MCODEBITS-1:0] HALT_OP     = MCODEBITS'(HALT_OP_DEF),
  parameter int                   MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int                   CNTW        = CNTW_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [MCODEBITS-1:0] opcode,
  input  logic                 ctl_branch,
  input  logic                 ctl_memread,
  input  logic                 ctl_memwrite,
  input  logic                 ctl_regwrite,
  input  logic                 ctl_memtoreg,
  input  logic                 alu_flag,
  input  logic                 mem_ack,
  output logic                 ir_load,
  output logic                 pc_en,
  output logic                 pc_sel,
  output logic                 reg_we,
  output logic                 mem_to_reg,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [CNTW-1:0]      inst_count
);

  seq_state_t      state_q, state_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            tmr_clr, tmr_en, tmr_tc;

  x9_wait_timer #(
    .W     (TIMER_W),
    .LIMIT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .tc_o   (tmr_tc)
  );

  // Next-state, strobe decode and retire counting.
  always_comb begin
    state_d    = state_q;
    done_d     = done_q;
    error_d    = error_q;
    cnt_d      = cnt_q;
    ir_load    = 1'b0;
    pc_en      = 1'b0;
    pc_sel     = 1'b0;
    reg_we     = 1'b0;
    mem_to_reg = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    tmr_clr    = 1'b0;
    tmr_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          cnt_d   = '0;
        end
      end
      FETCH: begin
        ir_load = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        if (opcode == HALT_OP) begin
          state_d = HALTED;
          done_d  = 1'b1;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (ctl_memread || ctl_memwrite) begin
          state_d = MEM;
          tmr_clr = 1'b1;
        end else if (ctl_branch) begin
          pc_en   = 1'b1;
          pc_sel  = alu_flag;
          state_d = FETCH;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = ctl_memwrite;
        // An ack on the last allowed cycle still completes the access.
        if (mem_ack) begin
          if (ctl_memwrite) begin
            pc_en   = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end else begin
          tmr_en = 1'b1;
          if (tmr_tc) begin
            state_d = ERROR;
            error_d = 1'b1;
          end
        end
      end
      WB: begin
        reg_we     = ctl_regwrite;
        mem_to_reg = ctl_memtoreg;
        pc_en      = 1'b1;
        state_d    = FETCH;
      end
      HALTED: begin
        if (start) begin
          state_d = FETCH;
          done_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Every PC update retires one instruction; the count sticks at all-ones.
    if (pc_en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Sequencer state and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      error_q <= error_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy       = (state_q != IDLE) && (state_q != HALTED) && (state_q != ERROR);
  assign done       = done_q;
  assign error      = error_q;
  assign inst_count = cnt_q;

endmodule

// File: tb/tb_x9_inst_sequencer.sv
// Directed bench for x9_inst_sequencer: each program is expanded into an expected
// per-cycle trace from the instruction-level timing rules, then replayed against the DUT.
module tb_x9_inst_sequencer;

  localparam int         CW   = 4;
  localparam int         TO   = 15;
  localparam logic [4:0] HALT = 5'b11111;
  localparam logic [4:0] ADD  = 5'd0;
  localparam logic [4:0] BEQ  = 5'd4;
  localparam logic [4:0] LB   = 5'd8;
  localparam logic [4:0] SB   = 5'd9;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [4:0]    opcode = '0;
  logic          ctl_branch = 1'b0, ctl_memread = 1'b0, ctl_memwrite = 1'b0;
  logic          ctl_regwrite = 1'b0, ctl_memtoreg = 1'b0;
  logic          alu_flag = 1'b0, mem_ack = 1'b0;
  logic          ir_load, pc_en, pc_sel, reg_we, mem_to_reg, mem_req, mem_we;
  logic          busy, done, error;
  logic [CW-1:0] inst_count;

  x9_inst_sequencer #(
    .MCODEBITS   (5),
    .HALT_OP     (HALT),
    .MEM_TIMEOUT (TO),
    .CNTW        (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .opcode       (opcode),
    .ctl_branch   (ctl_branch),
    .ctl_memread  (ctl_memread),
    .ctl_memwrite (ctl_memwrite),
    .ctl_regwrite (ctl_regwrite),
    .ctl_memtoreg (ctl_memtoreg),
    .alu_flag     (alu_flag),
    .mem_ack      (mem_ack),
    .ir_load      (ir_load),
    .pc_en        (pc_en),
    .pc_sel       (pc_sel),
    .reg_we       (reg_we),
    .mem_to_reg   (mem_to_reg),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .inst_count   (inst_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] opc;
    logic br, rd, wr, rw, m2r, flag;
    int   ack_at;   // MEM cycle on which ack arrives, 0 = never
  } ins_t;

  typedef struct {
    logic [4:0]    opc;
    logic          br, rd, wr, rw, m2r, flag, ack, st;
    logic          irl, pce, pcs, rwe, m2ro, mrq, mwe, bsy, dn, er;
    logic [CW-1:0] cnt;
  } cyc_t;

  ins_t          prog[$];
  cyc_t          tr[$];
  bit            m_done, m_err, noise;
  logic [CW-1:0] m_cnt;

  int checks = 0;
  int errors = 0;
  int irl_pos[$];
  int n_mrq, n_mwe, n_rwe, n_m2r, n_pce, n_pcs, first_done;

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  function automatic ins_t mk(logic [4:0] opc, logic br, logic rd, logic wr,
                              logic rw, logic m2r, logic flag, int ack);
    ins_t i;
    i.opc = opc; i.br = br; i.rd = rd; i.wr = wr;
    i.rw = rw; i.m2r = m2r; i.flag = flag; i.ack_at = ack;
    return i;
  endfunction

  // One busy cycle of instruction i with no strobes; callers add the strobes.
  function automatic cyc_t base(ins_t i);
    cyc_t c;
    c.opc = i.opc; c.br = i.br; c.rd = i.rd; c.wr = i.wr;
    c.rw = i.rw; c.m2r = i.m2r; c.flag = i.flag;
    c.ack = noise; c.st = noise;
    c.irl = 0; c.pce = 0; c.pcs = 0; c.rwe = 0; c.m2ro = 0; c.mrq = 0; c.mwe = 0;
    c.bsy = 1; c.dn = m_done; c.er = m_err; c.cnt = m_cnt;
    return c;
  endfunction

  task automatic retire();
    if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
  endtask

  // Expand prog[] into cycles: start, then per instruction F,D,(E),(MEM xk),(WB).
  task automatic gen_run();
    cyc_t c;
    ins_t i, z;
    bit   stop, to_wb;
    z = mk(5'd0, 0, 0, 0, 0, 0, 0, 0);
    c = base(z); c.st = 1; c.ack = 0; c.bsy = 0;
    tr.push_back(c);
    m_cnt = '0; m_done = 0;
    for (int j = 0; j < prog.size(); j++) begin
      i = prog[j];
      c = base(i); c.irl = 1; tr.push_back(c);
      c = base(i); tr.push_back(c);
      if (i.opc == HALT) begin
        m_done = 1;
        break;
      end
      c = base(i);
      if (!(i.rd || i.wr) && i.br) begin
        c.pce = 1; c.pcs = i.flag; tr.push_back(c); retire();
        continue;
      end
      tr.push_back(c);
      to_wb = 1;
      if (i.rd || i.wr) begin
        stop = 0; to_wb = 0;
        for (int k = 1; k <= TO; k++) begin
          c = base(i); c.ack = (k == i.ack_at); c.mrq = 1; c.mwe = i.wr;
          if (c.ack && i.wr) c.pce = 1;
          tr.push_back(c);
          if (c.ack) begin
            if (i.wr) retire(); else to_wb = 1;
            break;
          end
          if (k == TO) begin
            m_err = 1; stop = 1;
          end
        end
        if (stop) break;
      end
      if (to_wb) begin
        c = base(i); c.rwe = i.rw; c.m2ro = i.m2r; c.pce = 1;
        tr.push_back(c); retire();
      end
    end
  endtask

  // Non-busy cycles (IDLE, HALTED or ERROR) with a chosen start level.
  task automatic gen_idle(int n, bit st);
    cyc_t c;
    for (int j = 0; j < n; j++) begin
      c = base(mk(5'd0, 0, 0, 0, 0, 0, 0, 0));
      c.bsy = 0; c.st = st;
      tr.push_back(c);
    end
  endtask

  // Replay the trace: drive on the falling edge, compare 1 time unit later.
  task automatic run_trace(int maxn);
    irl_pos.delete();
    n_mrq = 0; n_mwe = 0; n_rwe = 0; n_m2r = 0; n_pce = 0; n_pcs = 0; first_done = -1;
    for (int n = 0; n < tr.size() && n < maxn; n++) begin
      @(negedge clk);
      opcode = tr[n].opc; ctl_branch = tr[n].br; ctl_memread = tr[n].rd;
      ctl_memwrite = tr[n].wr; ctl_regwrite = tr[n].rw; ctl_memtoreg = tr[n].m2r;
      alu_flag = tr[n].flag; mem_ack = tr[n].ack; start = tr[n].st;
      #1;
      chk("ir_load", n, ir_load, tr[n].irl);
      chk("pc_en", n, pc_en, tr[n].pce);
      chk("pc_sel", n, pc_sel, tr[n].pcs);
      chk("reg_we", n, reg_we, tr[n].rwe);
      chk("mem_to_reg", n, mem_to_reg, tr[n].m2ro);
      chk("mem_req", n, mem_req, tr[n].mrq);
      chk("mem_we", n, mem_we, tr[n].mwe);
      chk("busy", n, busy, tr[n].bsy);
      chk("done", n, done, tr[n].dn);
      chk("error", n, error, tr[n].er);
      chk("inst_count", n, inst_count, tr[n].cnt);
      if (ir_load === 1'b1) irl_pos.push_back(n);
      if (mem_req === 1'b1) n_mrq++;
      if (mem_we === 1'b1) n_mwe++;
      if (reg_we === 1'b1) n_rwe++;
      if (mem_to_reg === 1'b1) n_m2r++;
      if (pc_en === 1'b1) n_pce++;
      if (pc_sel === 1'b1) n_pcs++;
      if (done === 1'b1 && first_done < 0) first_done = n;
    end
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_ir_load"}, 0, ir_load, 0);
    chk({tag, "_pc_en"}, 0, pc_en, 0);
    chk({tag, "_pc_sel"}, 0, pc_sel, 0);
    chk({tag, "_reg_we"}, 0, reg_we, 0);
    chk({tag, "_mem_to_reg"}, 0, mem_to_reg, 0);
    chk({tag, "_mem_req"}, 0, mem_req, 0);
    chk({tag, "_mem_we"}, 0, mem_we, 0);
    chk({tag, "_busy"}, 0, busy, 0);
    chk({tag, "_done"}, 0, done, 0);
    chk({tag, "_error"}, 0, error, 0);
    chk({tag, "_inst_count"}, 0, inst_count, 0);
  endtask

  // Assert reset (optionally right now, mid-cycle), check outputs, then release.
  task automatic do_reset(bit wait_edge, string tag);
    if (wait_edge) @(negedge clk);
    reset = 0;
    #1;
    chk_all_zero(tag);
    start = 0; mem_ack = 0; opcode = '0; ctl_branch = 0; ctl_memread = 0;
    ctl_memwrite = 0; ctl_regwrite = 0; ctl_memtoreg = 0; alu_flag = 0;
    @(negedge clk);
    reset = 1;
    m_done = 0; m_err = 0; m_cnt = '0;
  endtask

  function automatic int gap(int a, int b);
    if (irl_pos.size() > b) return irl_pos[b] - irl_pos[a];
    return -1;
  endfunction

  initial begin
    noise = 0; m_done = 0; m_err = 0; m_cnt = '0;
    do_reset(1, "reset");

    // ALU program: add, add, halt
    prog = '{mk(ADD,0,0,0,1,0,0,0), mk(ADD,0,0,0,1,0,0,0), mk(HALT,0,0,0,0,0,0,0)};
    tr.delete(); gen_run(); gen_idle(3, 0); run_trace(1000);
    chk("t1_irl_count", 0, irl_pos.size(), 3);
    if (irl_pos.size() == 3) begin
      chk("t1_irl_0", 0, irl_pos[0], 1);
      chk("t1_irl_1", 0, irl_pos[1], 5);
      chk("t1_irl_2", 0, irl_pos[2], 9);
    end
    chk("t1_first_done", 0, first_done, 11);
    chk("t1_done", 0, done, 1);
    chk("t1_count", 0, inst_count, 2);

    // Branches taken/not taken, plus ignored start and stray acks while busy
    noise = 1;
    prog = '{mk(BEQ,1,0,0,0,0,1,0), mk(BEQ,1,0,0,0,0,0,0), mk(ADD,0,0,0,1,0,0,0),
             mk(HALT,0,0,0,0,0,0,0)};
    tr.delete(); gen_run(); gen_idle(3, 0); run_trace(1000);
    noise = 0;
    chk("t2_pc_en_n", 0, n_pce, 3);
    chk("t2_pc_sel_n", 0, n_pcs, 1);
    chk("t2_reg_we_n", 0, n_rwe, 1);
    chk("t2_beq_lat0", 0, gap(0, 1), 3);
    chk("t2_beq_lat1", 0, gap(1, 2), 3);
    chk("t2_count", 0, inst_count, 3);

    // Load with ack on the 3rd MEM cycle
    prog = '{mk(LB,0,1,0,1,1,0,3), mk(HALT,0,0,0,0,0,0,0)};
    tr.delete(); gen_run(); gen_idle(2, 0); run_trace(1000);
    chk("t3_mem_req_n", 0, n_mrq, 3);
    chk("t3_mem_we_n", 0, n_mwe, 0);
    chk("t3_reg_we_n", 0, n_rwe, 1);
    chk("t3_m2r_n", 0, n_m2r, 1);
    chk("t3_lat", 0, gap(0, 1), 7);

    // Store acked on the last allowed MEM cycle
    prog = '{mk(SB,0,0,1,0,0,0,TO), mk(HALT,0,0,0,0,0,0,0)};
    tr.delete(); gen_run(); gen_idle(2, 0); run_trace(1000);
    chk("t5_mem_req_n", 0, n_mrq, 15);
    chk("t5_lat", 0, gap(0, 1), 18);
    chk("t5_error", 0, error, 0);
    chk("t5_count", 0, inst_count, 1);

    // Store never acked: timeout, sticky error, start ignored
    prog = '{mk(SB,0,0,1,0,0,0,0)};
    tr.delete(); gen_run(); gen_idle(4, 1); run_trace(1000);
    chk("t4_mem_req_n", 0, n_mrq, 15);
    chk("t4_error", 0, error, 1);
    chk("t4_busy", 0, busy, 0);
    do_reset(1, "t4_clear");

    // Reset in the middle of a memory wait
    prog = '{mk(ADD,0,0,0,1,0,0,0), mk(SB,0,0,1,0,0,0,0)};
    tr.delete(); gen_run(); run_trace(10);
    chk("t6_in_mem", 0, mem_req, 1);
    chk("t6_cnt_before", 0, inst_count, 1);
    do_reset(0, "t6_midmem");

    // Saturation: 2^CW+5 branches
    prog.delete();
    for (int j = 0; j < (1 << CW) + 5; j++) prog.push_back(mk(BEQ,1,0,0,0,0,j[0],0));
    prog.push_back(mk(HALT,0,0,0,0,0,0,0));
    tr.delete(); gen_run(); gen_idle(2, 0); run_trace(2000);
    chk("t6_sat_count", 0, inst_count, 4'hF);
    chk("t6_sat_pc_en_n", 0, n_pce, 21);

    // Restart from HALTED clears the count
    prog = '{mk(HALT,0,0,0,0,0,0,0)};
    tr.delete(); gen_run(); gen_idle(2, 0); run_trace(100);
    chk("t6_restart_count", 0, inst_count, 0);
    chk("t6_restart_done", 0, done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
